// File: rtl/pipe_result_reader.sv
// Readback engine for the pipeline result memory: issues credit-limited reads over an address range,
// buffers returning words in a FWFT FIFO and streams them with their addresses and a running checksum.
module pipe_result_reader #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic [DW-1:0] dout,
  output logic [AW-1:0] dout_addr,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] checksum
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_nxt;

  logic [AW-1:0] base_r;
  logic [CW-1:0] count_r, issued, popped;
  logic          rd_vld_p1;
  logic [AW-1:0] rd_addr_p1;
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   occ;
  logic          push, pop, empty, full, cmd_start, last_issue, last_pop;

  function automatic logic [DW-1:0] add_wrap(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a + b;
  endfunction

  assign cmd_start   = start && (state == IDLE);
  assign last_issue  = (issued + CW'(1)) == count_r;
  assign last_pop    = (popped + CW'(1)) == count_r;
  assign mem_rd_addr = base_r + issued[AW-1:0];
  assign empty       = (occ == '0);
  assign full        = (occ == (PW+1)'(FIFO_DEPTH));
  assign push        = rd_vld_p1;
  assign pop         = dout_valid && dout_ready;
  assign dout_valid  = !empty;
  assign dout        = empty ? '0 : fifo_data[rd_ptr];
  assign dout_addr   = empty ? '0 : fifo_addr[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_start && (count != '0)) state_nxt = READ;
      READ:    if (mem_rd_en && last_issue)    state_nxt = DRAIN;
      DRAIN:   if (pop && last_pop)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Credit rule: buffered plus in-flight words never exceed the FIFO depth.
  always_comb begin
    busy      = (state != IDLE);
    mem_rd_en = (state == READ) && (issued < count_r) &&
                (({1'b0, occ} + (PW+2)'(rd_vld_p1)) < (PW+2)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r    <= '0;
      count_r   <= '0;
      issued    <= '0;
      popped    <= '0;
      checksum  <= '0;
      done      <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      done      <= (cmd_start && (count == '0)) || ((state == DRAIN) && pop && last_pop);
      rd_vld_p1 <= mem_rd_en;
      if (cmd_start) begin
        base_r   <= base_addr;
        count_r  <= count;
        issued   <= '0;
        popped   <= '0;
        checksum <= '0;
      end else begin
        if (mem_rd_en) issued <= issued + CW'(1);
        if (pop) begin
          popped   <= popped + CW'(1);
          checksum <= add_wrap(checksum, dout);
        end
      end
    end
  end

  // Stage p1: request address travels with the 1-cycle memory latency.
  always_ff @(posedge clk) begin
    rd_addr_p1 <= mem_rd_addr;
    if (push) begin
      fifo_data[wr_ptr] <= mem_rd_data;
      fifo_addr[wr_ptr] <= rd_addr_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PW+1)'(1);
        2'b01:   occ <= occ - (PW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule
